// File: rtl/valu_arbiter.sv
// valu_arbiter: round-robin two-requester front end for one shared vector ALU; `define VALU_TIMEOUT_EN adds a WAIT-state watchdog
module valu_arbiter #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [1:0]       r0_req_op,
  input  logic [1:0]       r0_req_sew,
  input  logic [63:0]      r0_req_vs1,
  input  logic [63:0]      r0_req_vs2,
  input  logic [TAG_W-1:0] r0_req_tag,
  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [1:0]       r1_req_op,
  input  logic [1:0]       r1_req_sew,
  input  logic [63:0]      r1_req_vs1,
  input  logic [63:0]      r1_req_vs2,
  input  logic [TAG_W-1:0] r1_req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [63:0]      rsp_data,
  output logic             rsp_err,
  output logic             alu_valid_in,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_sew,
  output logic [63:0]      alu_vs1,
  output logic [63:0]      alu_vs2,
  input  logic             alu_valid_out,
  input  logic [63:0]      alu_result
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state;
  logic             rr_ptr, g0, g1, fire, bad;
  logic [1:0]       op_w, sew_w;
  logic [63:0]      vs1_w, vs2_w;
  logic [TAG_W-1:0] tag_w;
`ifdef VALU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wcnt;
`endif
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  always_comb begin
    g0           = rr_ptr ? r0_req_valid & ~r1_req_valid : r0_req_valid;
    g1           = rr_ptr ? r1_req_valid : r1_req_valid & ~r0_req_valid;
    r0_req_ready = ~rst & (state == IDLE) & g0;
    r1_req_ready = ~rst & (state == IDLE) & g1;
    fire         = r0_req_ready | r1_req_ready;
    op_w         = g1 ? r1_req_op  : r0_req_op;
    sew_w        = g1 ? r1_req_sew : r0_req_sew;
    vs1_w        = g1 ? r1_req_vs1 : r0_req_vs1;
    vs2_w        = g1 ? r1_req_vs2 : r0_req_vs2;
    tag_w        = g1 ? r1_req_tag : r0_req_tag;
    bad          = (&op_w) | (&sew_w);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_tag      <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      alu_valid_in <= 1'b0;
      alu_op       <= '0;
      alu_sew      <= '0;
      alu_vs1      <= '0;
      alu_vs2      <= '0;
`ifdef VALU_TIMEOUT_EN
      wcnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (fire) begin
          alu_op       <= op_w;
          alu_sew      <= sew_w;
          alu_vs1      <= vs1_w;
          alu_vs2      <= vs2_w;
          rsp_id       <= g1;
          rsp_tag      <= tag_w;
          rsp_data     <= '0;
          rsp_err      <= bad;
          rsp_valid    <= bad;
          alu_valid_in <= ~bad;
          state        <= bad ? RESP : ISSUE;
        end
        ISSUE: begin
          alu_valid_in <= 1'b0;
          state        <= WAIT;
`ifdef VALU_TIMEOUT_EN
          wcnt         <= '0;
`endif
        end
        WAIT: begin
          if (alu_valid_out) begin
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef VALU_TIMEOUT_EN
          else if (wcnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else
            wcnt <= wcnt + CW'(1);
`endif
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr_ptr    <= ~rsp_id;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/valu_arbiter.md
Name: valu_arbiter

Overview:
Shares one vector ALU (VADD/VSUB/VMUL; SEW 8/16/32; 64-bit operands) between two requesters, for example the scalar-core issue port and the vector loop engine.
- Arbitrates round-robin and registers the winning command.
- Pulses the ALU start and holds its operands stable for the whole multi-cycle operation.
- Returns the tagged result on a shared response channel with backpressure.
- Rejects illegal op/sew codes locally, so the ALU never hangs on them.

Parameters:
TAG_W, 4, width of the requester transaction tag echoed on the response.
TIMEOUT_CYCLES, 64, watchdog limit in WAIT state (used only with VALU_TIMEOUT_EN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset; the top ties the ALU rst_n to ~rst.
rK_req_valid  in  1  requester K (K=0,1) has a command.
rK_req_ready  out  1  requester K command accepted this cycle.
rK_req_op  in  2  00=VADD, 01=VSUB, 10=VMUL, 11=illegal.
rK_req_sew  in  2  00=8b, 01=16b, 10=32b, 11=illegal.
rK_req_vs1  in  64  operand 1.
rK_req_vs2  in  64  operand 2.
rK_req_tag  in  TAG_W  transaction tag.
rsp_valid  out  1  response valid; held until accepted.
rsp_ready  in  1  response sink ready.
rsp_id  out  1  requester index of the response.
rsp_tag  out  TAG_W  echoed tag.
rsp_data  out  64  ALU result; 0 on error.
rsp_err  out  1  1 = illegal command or timeout.
alu_valid_in  out  1  single-cycle start pulse to the ALU.
alu_op  out  2  registered op, stable from ISSUE through WAIT.
alu_sew  out  2  registered sew, stable from ISSUE through WAIT.
alu_vs1  out  64  registered operand 1.
alu_vs2  out  64  registered operand 2.
alu_valid_out  in  1  ALU result-ready pulse.
alu_result  in  64  ALU result.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset: IDLE, rr_ptr=0, and every output 0 (rsp_*, alu_*, rK_req_ready).
- IDLE, arbitration:
  - grant = requester rr_ptr if its valid is high, else the other requester if its valid is high.
  - rK_req_ready = (state==IDLE) & grant_K; combinational, at most one high.
  - A transfer fires on valid&ready and captures op, sew, vs1, vs2, tag and id.
- IDLE, next state after a transfer:
  - op==11 or sew==11: go to RESP with err=1 and data=0; the ALU is not started.
  - Otherwise: go to ISSUE.
- ISSUE: alu_valid_in=1 for exactly one cycle, then WAIT.
- WAIT:
  - On alu_valid_out=1: capture alu_result into rsp_data, err=0, go to RESP.
  - alu_valid_out in any other state is ignored.
- RESP:
  - rsp_valid=1, with rsp_id/tag/data/err stable until rsp_ready=1.
  - On that handshake: rsp_valid drops next cycle, rr_ptr = ~rsp_id, go to IDLE.
  - No new command is accepted in the RESP cycle itself.
- alu_op/sew/vs1/vs2 change only on an IDLE transfer.
- Latency with rsp_ready tied high, transfer at cycle T:
  - VADD/VSUB: rsp_valid at T+4.
  - VMUL SEW8: rsp_valid at T+8.
  - VMUL SEW16/32: rsp_valid at T+6.
  - Illegal command: rsp_valid at T+1.
- Throughput: one command in flight; minimum 2 cycles between the response handshake and the next ALU start.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Simultaneous requests at reset: requester 0 wins.
- Backpressure: rsp_ready low holds RESP indefinitely; requesters see ready=0 throughout.
- Reset mid-operation: immediate return to IDLE and outputs cleared; the ALU is reset by the same rst, so no stale alu_valid_out can arrive.

Optional Feature:
VALU_TIMEOUT_EN:
- Defined: a WAIT-state counter starts at 0 on entry to WAIT. When it reaches TIMEOUT_CYCLES without alu_valid_out, go to RESP with err=1 and data=0. A late alu_valid_out is ignored, because the block is then no longer in WAIT.
- Undefined: no counter; WAIT waits indefinitely, and rsp_err is set only for illegal commands.

Test Plan:
- Single VADD: r0 op=00 sew=00 vs1=0x0102030405060708, vs2=0x0101010101010101, tag=3 -> rsp at T+4: data=0x0203040506070809, id=0, tag=3, err=0.
- VMUL SEW8: vs1=0x0000000000000302, vs2=0x0000000000000504 -> rsp at T+8: data=0x0000000000000F08, err=0. The bench checks alu_vs1/alu_vs2 are held constant through WAIT.
- Contention: r0 and r1 both valid with VSUB for 4 commands each -> grant order 0,1,0,1,... and rsp_id order matches.
- Illegal command: r1 op=11, tag=7 -> rsp at T+1: err=1, data=0, id=1, tag=7; alu_valid_in never asserted.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and all fields stable and req_ready=0 throughout; a single handshake follows when ready rises.
- Reset mid-VMUL in WAIT, then timeout (with VALU_TIMEOUT_EN, TIMEOUT_CYCLES=8, ALU stub that never responds):
  - Reset -> next cycle all outputs 0 and state IDLE.
  - Timeout -> rsp err=1 at 8 cycles after entering WAIT.
